// File: rtl/eth_l2_pkg.sv
// rtl/eth_l2_pkg.sv - shared types and constants for the Ethernet L2 receive/transmit path
package eth_l2_pkg;

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_IDLE      = 3'd1,
        S_PREAMBLE  = 3'd2,
        S_HEADER    = 3'd3,
        S_PAYLOAD   = 3'd4
    } l2_state_e;

    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    // Good-frame residue expressed in MSB-first bit order; the reflected
    // register must be bit-reversed before comparing against it.
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFFFFFFFFFF;

    localparam int HDR_LEN = 14;
    localparam int FCS_LEN = 4;

    // Byte idx of a MAC in wire order (idx 0 = bits [47:40]).
    function automatic logic [7:0] macByte(input logic [47:0] mac, input logic [2:0] idx);
        case (idx)
            3'd0:    macByte = mac[47:40];
            3'd1:    macByte = mac[39:32];
            3'd2:    macByte = mac[31:24];
            3'd3:    macByte = mac[23:16];
            3'd4:    macByte = mac[15:8];
            default: macByte = mac[7:0];
        endcase
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// rtl/eth_crc32_d8.sv - combinational IEEE 802.3 CRC-32 update, one byte, reflected, LSB first
// Ports: CrcIn (current register), Data (byte), CrcOut (register after the byte).
module eth_crc32_d8
    import eth_l2_pkg::*;
(
    input  logic [31:0] CrcIn,
    input  logic [7:0]  Data,
    output logic [31:0] CrcOut
);

    always_comb begin
        logic [31:0] c;
        c = CrcIn;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ Data[i]) begin
                c = (c >> 1) ^ CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        CrcOut = c;
    end

endmodule

// File: rtl/eth_rx_l2_filter.sv
// rtl/eth_rx_l2_filter.sv - receive L2 filter: strips preamble/SFD, checks DA/EtherType, forwards payload
// Inputs : Clk, Rst (async, high), RxVal byte strobe, RxDv envelope, RxEr, RxD, InnerMAC.
// Outputs: SoFOut/EoFOut/ValOut pulses, ErrOut (valid with EoFOut), DataOut, SrcMAC, DropPulse.
// Build option: ETH_RX_PROMISC_EN bypasses the destination MAC check.
module eth_rx_l2_filter
    import eth_l2_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE   = 16'h0806,
    parameter int          MAX_LEN     = 1518,
    parameter int          MIN_PAYLOAD = 46
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RxVal,
    input  logic        RxDv,
    input  logic        RxEr,
    input  logic [7:0]  RxD,
    input  logic [47:0] InnerMAC,
    output logic        SoFOut,
    output logic        EoFOut,
    output logic        ValOut,
    output logic        ErrOut,
    output logic [7:0]  DataOut,
    output logic [47:0] SrcMAC,
    output logic        DropPulse
);

    localparam logic [2:0] WAIT_IDLE = S_WAIT_IDLE;
    localparam logic [2:0] IDLE      = S_IDLE;
    localparam logic [2:0] PREAMBLE  = S_PREAMBLE;
    localparam logic [2:0] HEADER    = S_HEADER;
    localparam logic [2:0] PAYLOAD   = S_PAYLOAD;

    localparam logic [10:0] MAX_CNT  = 11'(MAX_LEN);
    localparam logic [10:0] MIN_CNT  = 11'(HDR_LEN + FCS_LEN + MIN_PAYLOAD);
    localparam logic [10:0] LAST_HDR = 11'(HDR_LEN - 1);

    logic [2:0]       state;
    logic [31:0]      crc, crcNext, crcMsbFirst;
    logic [10:0]      byteCnt, cntInc;
    logic [4:0][7:0]  shReg;        // [4] is the oldest held byte
    logic [2:0]       held;
    logic [47:0]      srcStage;
    logic             dstUni, dstBc, dstOk, typeHiOk, rxErSeen, sofDone;
    logic             heldFull, overflow, crcBad, shortFrame;
    logic             emitByte, emitEof, emitErr;

    eth_crc32_d8 uCrc (
        .CrcIn  (crc),
        .Data   (RxD),
        .CrcOut (crcNext)
    );

`ifdef ETH_RX_PROMISC_EN
    assign dstOk = 1'b1;
`else
    assign dstOk = dstUni | dstBc;
`endif

    assign crcMsbFirst = {<<{crc}};
    assign crcBad      = (crcMsbFirst != CRC_RESIDUE);
    assign shortFrame  = (byteCnt < MIN_CNT);
    assign heldFull    = (held == 3'd5);
    assign overflow    = RxDv && (byteCnt >= MAX_CNT);
    assign cntInc      = (byteCnt == 11'h7FF) ? byteCnt : byteCnt + 11'd1;

    // A payload strobe releases the oldest byte only once the 4 FCS bytes
    // are guaranteed to be behind it in the shift register.
    always_comb begin
        emitByte = 1'b0;
        emitEof  = 1'b0;
        emitErr  = 1'b0;
        if (RxVal && state == PAYLOAD && heldFull) begin
            emitByte = 1'b1;
            if (!RxDv) begin
                emitEof = 1'b1;
                emitErr = crcBad | rxErSeen | RxEr | shortFrame;
            end else if (overflow) begin
                emitEof = 1'b1;
                emitErr = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= WAIT_IDLE;
            crc       <= '0;
            byteCnt   <= '0;
            shReg     <= '0;
            held      <= '0;
            srcStage  <= '0;
            dstUni    <= 1'b0;
            dstBc     <= 1'b0;
            typeHiOk  <= 1'b0;
            rxErSeen  <= 1'b0;
            sofDone   <= 1'b0;
            SoFOut    <= 1'b0;
            EoFOut    <= 1'b0;
            ValOut    <= 1'b0;
            ErrOut    <= 1'b0;
            DataOut   <= '0;
            SrcMAC    <= '0;
            DropPulse <= 1'b0;
        end else begin
            ValOut    <= emitByte;
            EoFOut    <= emitEof;
            ErrOut    <= emitErr;
            SoFOut    <= emitByte & ~sofDone;
            DropPulse <= 1'b0;
            if (emitByte) begin
                DataOut <= shReg[4];
                if (!sofDone) begin
                    SrcMAC  <= srcStage;
                    sofDone <= 1'b1;
                end
            end

            if (RxVal) begin
                case (state)
                    WAIT_IDLE: if (!RxDv) state <= IDLE;
                    IDLE: if (RxDv) state <= (RxD == PREAMBLE_BYTE) ? PREAMBLE : WAIT_IDLE;
                    PREAMBLE: begin
                        if (!RxDv) begin
                            state <= WAIT_IDLE;
                        end else if (RxD == SFD_BYTE) begin
                            state    <= HEADER;
                            crc      <= CRC_INIT;
                            byteCnt  <= '0;
                            rxErSeen <= RxEr;
                            dstUni   <= 1'b1;
                            dstBc    <= 1'b1;
                        end else if (RxD != PREAMBLE_BYTE) begin
                            state <= WAIT_IDLE;
                        end
                    end
                    HEADER: begin
                        if (!RxDv) begin
                            state <= IDLE;
                        end else begin
                            crc      <= crcNext;
                            byteCnt  <= cntInc;
                            rxErSeen <= rxErSeen | RxEr;
                            if (byteCnt < 11'd6) begin
                                dstUni <= dstUni & (RxD == macByte(InnerMAC, byteCnt[2:0]));
                                dstBc  <= dstBc & (RxD == macByte(BCAST_MAC, byteCnt[2:0]));
                            end else if (byteCnt < 11'd12) begin
                                srcStage <= {srcStage[39:0], RxD};
                            end else if (byteCnt == 11'd12) begin
                                typeHiOk <= (RxD == ETHERTYPE[15:8]);
                            end else if (byteCnt == LAST_HDR) begin
                                if (dstOk && typeHiOk && RxD == ETHERTYPE[7:0]) begin
                                    state   <= PAYLOAD;
                                    held    <= '0;
                                    sofDone <= 1'b0;
                                end else begin
                                    DropPulse <= 1'b1;
                                    state     <= WAIT_IDLE;
                                end
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (!RxDv) begin
                            state <= IDLE;
                            if (!heldFull) DropPulse <= 1'b1;
                        end else if (overflow) begin
                            state <= WAIT_IDLE;
                        end else begin
                            crc      <= crcNext;
                            byteCnt  <= cntInc;
                            rxErSeen <= rxErSeen | RxEr;
                            shReg    <= {shReg[3:0], RxD};
                            if (!heldFull) held <= held + 3'd1;
                        end
                    end
                    default: state <= WAIT_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_l2_filter.sv
// tb/tb_eth_rx_l2_filter.sv - directed self-checking bench for eth_rx_l2_filter
module tb_eth_rx_l2_filter;

    logic        Clk = 1'b0;
    logic        Rst, RxVal, RxDv, RxEr;
    logic [7:0]  RxD;
    logic [47:0] InnerMAC;
    logic        SoFOut, EoFOut, ValOut, ErrOut, DropPulse;
    logic [7:0]  DataOut;
    logic [47:0] SrcMAC;

    always #5 Clk = ~Clk;

    eth_rx_l2_filter dut (
        .Clk(Clk), .Rst(Rst), .RxVal(RxVal), .RxDv(RxDv), .RxEr(RxEr), .RxD(RxD),
        .InnerMAC(InnerMAC), .SoFOut(SoFOut), .EoFOut(EoFOut), .ValOut(ValOut),
        .ErrOut(ErrOut), .DataOut(DataOut), .SrcMAC(SrcMAC), .DropPulse(DropPulse)
    );

    localparam logic [47:0] MY_MAC  = 48'h0A1B2C3D4E5F;
    localparam logic [47:0] FOREIGN = 48'h0A1B2C3D4E50;
    localparam logic [47:0] BCAST   = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] SRC_A   = 48'h020000000001;
    localparam logic [47:0] SRC_B   = 48'h02AABBCCDDEE;

    logic [7:0] arpBody [0:27] = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
                                   8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                                   8'hC0, 8'hA8, 8'h00, 8'h01,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                   8'hC0, 8'hA8, 8'h00, 8'h02};

    int total = 0;
    int bad = 0;
    logic [7:0] frm[$];
    logic [7:0] pl[$];
    logic [7:0] rxQ[$];
    int sofCnt, eofCnt, dropCnt, sofIdx, eofIdx, strayCnt, latBad, spaceBad;
    int lastValCyc, cyc, curGap;
    logic eofErr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearStats();
        rxQ.delete();
        sofCnt = 0; eofCnt = 0; dropCnt = 0; sofIdx = -1; eofIdx = -1;
        strayCnt = 0; latBad = 0; spaceBad = 0; lastValCyc = -1; eofErr = 1'bx;
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic tick();
        logic strobed;
        strobed = RxVal;
        @(posedge Clk);
        #1;
        cyc++;
        if (ValOut) begin
            if (SoFOut) begin sofCnt++; sofIdx = rxQ.size(); end
            if (EoFOut) begin eofCnt++; eofIdx = rxQ.size(); eofErr = ErrOut; end
            rxQ.push_back(DataOut);
            if (!strobed) latBad++;
            if (lastValCyc >= 0 && cyc - lastValCyc != curGap) spaceBad++;
            lastValCyc = cyc;
        end else if (SoFOut || EoFOut) begin
            strayCnt++;
        end
        if (ErrOut && !EoFOut) strayCnt++;
        if (DropPulse) dropCnt++;
    endtask

    task automatic putByte(input logic dv, input logic er, input logic [7:0] d, input int gap);
        RxVal = 1'b1; RxDv = dv; RxEr = er; RxD = d;
        tick();
        RxVal = 1'b0; RxEr = 1'b0;
        for (int g = 1; g < gap; g++) tick();
    endtask

    function automatic logic [31:0] crcByte(input logic [31:0] c0, input logic [7:0] d);
        logic [31:0] c;
        c = c0;
        for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic buildFrame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                              input int plen, input bit arp, input bit flip);
        logic [31:0] c, fcs;
        frm.delete(); pl.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
        frm.push_back(et[15:8]); frm.push_back(et[7:0]);
        for (int i = 0; i < plen; i++) begin
            if (arp) pl.push_back((i < 28) ? arpBody[i] : 8'h00);
            else     pl.push_back(8'((i * 7 + 3) & 255));
            frm.push_back(pl[i]);
        end
        c = 32'hFFFFFFFF;
        foreach (frm[i]) c = crcByte(c, frm[i]);
        fcs = ~c;
        if (flip) fcs = fcs ^ 32'h00010000;
        frm.push_back(fcs[7:0]);   frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]); frm.push_back(fcs[31:24]);
    endtask

    task automatic sendFrame(input int gap, input int errAt, input int rstAt);
        for (int i = 0; i < 7; i++) putByte(1'b1, 1'b0, 8'h55, gap);
        putByte(1'b1, 1'b0, 8'hD5, gap);
        foreach (frm[i]) begin
            if (i == rstAt) begin
                Rst = 1'b1;
                #2;
                check("rstmid.ValOut", 64'(ValOut), 64'd0);
                check("rstmid.DataOut", 64'(DataOut), 64'd0);
                check("rstmid.SrcMAC", 64'(SrcMAC), 64'd0);
                Rst = 1'b0;
            end
            putByte(1'b1, i == errAt, frm[i], gap);
        end
        putByte(1'b0, 1'b0, 8'h00, gap);
        for (int i = 0; i < 3; i++) putByte(1'b0, 1'b0, 8'h00, 1);
    endtask

    task automatic expectFrame(input string tag, input int n, input logic err, input int drops);
        int mism;
        mism = 0;
        foreach (rxQ[i]) if (i >= pl.size() || rxQ[i] !== pl[i]) mism++;
        check({tag, ".bytes"}, 64'(rxQ.size()), 64'(n));
        check({tag, ".data"}, 64'(mism), 64'd0);
        check({tag, ".sofcnt"}, 64'(sofCnt), 64'(n > 0));
        check({tag, ".eofcnt"}, 64'(eofCnt), 64'(n > 0));
        if (n > 0) begin
            check({tag, ".sofidx"}, 64'(sofIdx), 64'd0);
            check({tag, ".eofidx"}, 64'(eofIdx), 64'(n - 1));
            check({tag, ".err"}, 64'(eofErr), 64'(err));
        end
        check({tag, ".drop"}, 64'(dropCnt), 64'(drops));
        check({tag, ".stray"}, 64'(strayCnt), 64'd0);
        check({tag, ".latency"}, 64'(latBad), 64'd0);
        check({tag, ".spacing"}, 64'(spaceBad), 64'd0);
    endtask

    initial begin
        Rst = 1'b1; RxVal = 1'b0; RxDv = 1'b0; RxEr = 1'b0; RxD = 8'h00;
        InnerMAC = MY_MAC; cyc = 0; curGap = 1;
        clearStats();
        for (int i = 0; i < 3; i++) tick();
        check("reset.ValOut", 64'(ValOut), 64'd0);
        check("reset.SoFOut", 64'(SoFOut), 64'd0);
        check("reset.EoFOut", 64'(EoFOut), 64'd0);
        check("reset.ErrOut", 64'(ErrOut), 64'd0);
        check("reset.DataOut", 64'(DataOut), 64'd0);
        check("reset.SrcMAC", 64'(SrcMAC), 64'd0);
        check("reset.DropPulse", 64'(DropPulse), 64'd0);
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) putByte(1'b0, 1'b0, 8'h00, 1);

        clearStats(); buildFrame(BCAST, SRC_A, 16'h0806, 46, 1'b1, 1'b0); sendFrame(1, -1, -1);
        expectFrame("bcast", 46, 1'b0, 0);
        check("bcast.first", 64'(rxQ[0]), 64'h00);
        check("bcast.srcmac", 64'(SrcMAC), 64'(SRC_A));

        clearStats(); buildFrame(BCAST, SRC_A, 16'h0806, 46, 1'b1, 1'b1); sendFrame(1, -1, -1);
        expectFrame("badfcs", 46, 1'b1, 0);

        clearStats(); buildFrame(FOREIGN, SRC_B, 16'h0806, 46, 1'b0, 1'b0); sendFrame(1, -1, -1);
`ifdef ETH_RX_PROMISC_EN
        expectFrame("foreign", 46, 1'b0, 0);
`else
        expectFrame("foreign", 0, 1'b0, 1);
`endif

        clearStats(); buildFrame(MY_MAC, SRC_B, 16'h0800, 46, 1'b0, 1'b0); sendFrame(1, -1, -1);
        expectFrame("etype", 0, 1'b0, 1);

        clearStats(); buildFrame(MY_MAC, SRC_B, 16'h0806, 50, 1'b0, 1'b0); sendFrame(1, -1, -1);
        expectFrame("ucast", 50, 1'b0, 0);
        check("ucast.srcmac", 64'(SrcMAC), 64'(SRC_B));

        clearStats(); buildFrame(BCAST, SRC_A, 16'h0806, 46, 1'b0, 1'b0); sendFrame(1, 34, -1);
        expectFrame("rxer", 46, 1'b1, 0);

        clearStats(); buildFrame(BCAST, SRC_A, 16'h0806, 20, 1'b0, 1'b0); sendFrame(1, -1, -1);
        expectFrame("short", 20, 1'b1, 0);

        clearStats(); buildFrame(BCAST, SRC_A, 16'h0806, 45, 1'b0, 1'b0); sendFrame(1, -1, -1);
        expectFrame("min45", 45, 1'b1, 0);

        clearStats(); buildFrame(BCAST, SRC_A, 16'h0806, 0, 1'b0, 1'b0); sendFrame(1, -1, -1);
        expectFrame("trunc", 0, 1'b0, 1);

        curGap = 2;
        clearStats(); buildFrame(BCAST, SRC_A, 16'h0806, 46, 1'b1, 1'b0); sendFrame(2, -1, -1);
        expectFrame("m100", 46, 1'b0, 0);
        curGap = 1;

        clearStats(); buildFrame(BCAST, SRC_B, 16'h0806, 46, 1'b0, 1'b0); sendFrame(1, -1, 24);
        check("rstmid.bytes", 64'(rxQ.size()), 64'd5);
        check("rstmid.eofcnt", 64'(eofCnt), 64'd0);
        check("rstmid.drop", 64'(dropCnt), 64'd0);
        clearStats(); buildFrame(BCAST, SRC_A, 16'h0806, 46, 1'b1, 1'b0); sendFrame(1, -1, -1);
        expectFrame("afterrst", 46, 1'b0, 0);
        check("afterrst.srcmac", 64'(SrcMAC), 64'(SRC_A));

        clearStats(); buildFrame(BCAST, SRC_A, 16'h0806, 1510, 1'b0, 1'b0); sendFrame(1, -1, -1);
        expectFrame("ovf", 1500, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
